// File: rtl/decode_rf.sv
// decode_rf: RV64 decode stage with a 32x64 integer register file.
// Accepts instructions from fetch, decodes the immediate, reads rs1/rs2 and
// presents operands to the ALU through a registered valid/retry stage. ALU
// write-backs retire in issue order via a pending-rd FIFO; any instruction
// whose sources hit a pending rd is held at fetch until that rd is written.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_insn_valid/if_insn/if_pc   instruction offered by fetch
//   if_insn_retry     fetch must hold its instruction this cycle
//   insn_valid/insn/pc/sign_ext/src1/src2   registered operands to ALU
//   insn_retry        ALU did not take this cycle's instruction
//   dest_valid/dest_long/dest     write-back from ALU (retires FIFO head)
module decode_rf #(
  parameter int unsigned PEND_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_insn_valid,
  input  logic [31:0] if_insn,
  input  logic [63:0] if_pc,
  output logic        if_insn_retry,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [63:0] pc,
  output logic [63:0] sign_ext,
  output logic [63:0] src1,
  output logic [63:0] src2,
  input  logic        insn_retry,
  input  logic        dest_valid,
  input  logic        dest_long,
  input  logic [63:0] dest
);

  localparam int unsigned PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_OP32     = 7'b0111011,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111
  } opcode_e;

  // Architectural and pipeline state
  logic [63:0]   rf_q   [32];
  logic [4:0]    pend_q [PEND_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          insn_valid_q, insn_valid_d;
  logic [31:0]   insn_q, insn_d;
  logic [63:0]   pc_q, pc_d, sign_ext_q, sign_ext_d;
  logic [63:0]   src1_q, src1_d, src2_q, src2_d;

  // Decode / control
  opcode_e       opc;
  logic [4:0]    rs1, rs2, rd, pop_rd;
  logic          writes_rd, pop, push, full, hazard, stall, accept;
  logic [63:0]   imm, wb_data, rs1_val, rs2_val;
  logic [PW-1:0] idx;

  assign opc     = opcode_e'(if_insn[6:0]);
  assign rs1     = if_insn[19:15];
  assign rs2     = if_insn[24:20];
  assign rd      = if_insn[11:7];
  assign pop     = dest_valid && (count_q != '0);
  assign pop_rd  = pend_q[rd_ptr_q];
  assign wb_data = dest_long ? dest : {{32{dest[31]}}, dest[31:0]};
  assign full    = (count_q == (PW+1)'(PEND_DEPTH));

  always_comb begin
    imm       = '0;
    writes_rd = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: begin
        imm       = {{52{if_insn[31]}}, if_insn[31:20]};
        writes_rd = 1'b1;
      end
      OPC_STORE:  imm = {{52{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
      OPC_BRANCH: imm = {{51{if_insn[31]}}, if_insn[31], if_insn[7],
                         if_insn[30:25], if_insn[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: begin
        imm       = {{32{if_insn[31]}}, if_insn[31:12], 12'h000};
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm       = {{43{if_insn[31]}}, if_insn[31], if_insn[19:12],
                     if_insn[20], if_insn[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OPC_OP, OPC_OP32: writes_rd = 1'b1;
      default: begin
        imm       = '0;
        writes_rd = 1'b0;
      end
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  // Scoreboard: scan occupied slots from the head. The head is skipped when it
  // retires this cycle because its value is forwarded by the read path below.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < PEND_DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (((PW+1)'(k) < count_q) && !(k == 0 && pop)) begin
        if ((rs1 != 5'd0 && rs1 == pend_q[idx]) ||
            (rs2 != 5'd0 && rs2 == pend_q[idx]))
          hazard = 1'b1;
      end
    end
  end

  assign stall         = full || hazard;
  assign if_insn_retry = stall || (insn_valid_q && insn_retry);
  assign accept        = if_insn_valid && !if_insn_retry;
  assign push          = accept && writes_rd;

  // Write-first register read
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (pop && pop_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) rs2_val = (pop && pop_rd == rs2) ? wb_data : rf_q[rs2];
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    insn_valid_d = insn_valid_q;
    insn_d       = insn_q;
    pc_d         = pc_q;
    sign_ext_d   = sign_ext_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    if (accept) begin
      insn_valid_d = 1'b1;
      insn_d       = if_insn;
      pc_d         = if_pc;
      sign_ext_d   = imm;
      src1_d       = rs1_val;
      src2_d       = rs2_val;
    end else if (!insn_retry) begin
      insn_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q         <= '{default: '0};
      pend_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      insn_valid_q <= 1'b0;
      insn_q       <= '0;
      pc_q         <= '0;
      sign_ext_q   <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
    end else begin
      if (pop) begin
        if (pop_rd != 5'd0) rf_q[pop_rd] <= wb_data;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        pend_q[wr_ptr_q] <= rd;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      count_q      <= count_d;
      insn_valid_q <= insn_valid_d;
      insn_q       <= insn_d;
      pc_q         <= pc_d;
      sign_ext_q   <= sign_ext_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
    end
  end

  assign insn_valid = insn_valid_q;
  assign insn       = insn_q;
  assign pc         = pc_q;
  assign sign_ext   = sign_ext_q;
  assign src1       = src1_q;
  assign src2       = src2_q;

endmodule

// File: tb/tb_decode_rf.sv
// tb_decode_rf: directed bench for decode_rf with a queue/array reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_decode_rf;

  localparam int PEND_DEPTH = 4;

  logic        clk, reset;
  logic        if_insn_valid, if_insn_retry;
  logic [31:0] if_insn, insn;
  logic [63:0] if_pc, pc, sign_ext, src1, src2, dest;
  logic        insn_valid, insn_retry, dest_valid, dest_long;

  decode_rf #(.PEND_DEPTH(PEND_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_insn_valid(if_insn_valid), .if_insn(if_insn), .if_pc(if_pc),
    .if_insn_retry(if_insn_retry),
    .insn_valid(insn_valid), .insn(insn), .pc(pc), .sign_ext(sign_ext),
    .src1(src1), .src2(src2), .insn_retry(insn_retry),
    .dest_valid(dest_valid), .dest_long(dest_long), .dest(dest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mrf [32];
  logic [4:0]  pend [$];
  logic        model_ok = 1'b0;
  logic        m_valid;
  logic [31:0] m_insn;
  logic [63:0] m_pc, m_imm, m_src1, m_src2, m_wval;
  logic        m_pop, m_haz, m_retry, m_acc;
  logic [4:0]  c_rs1, c_rs2, c_rd, m_rd;

  function automatic logic [63:0] imm_of(input logic [31:0] i);
    logic signed [63:0] s;
    s = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: s = $signed(i[31:20]);
      7'h23: s = $signed({i[31:25], i[11:7]});
      7'h63: s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'h37, 7'h17: s = $signed({i[31:12], 12'h000});
      7'h6F: s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: s = 0;
    endcase
    return s;
  endfunction

  function automatic logic has_rd(input logic [31:0] i);
    return (i[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h1B, 7'h3B})
           && (i[11:7] != 5'd0);
  endfunction

  always begin
    @(negedge clk);
    #3;
    c_rs1 = if_insn[19:15];
    c_rs2 = if_insn[24:20];
    c_rd  = if_insn[11:7];
    m_pop = dest_valid && (pend.size() != 0);
    m_haz = 1'b0;
    foreach (pend[k])
      if (!(k == 0 && m_pop) &&
          ((c_rs1 != 0 && c_rs1 == pend[k]) || (c_rs2 != 0 && c_rs2 == pend[k])))
        m_haz = 1'b1;
    m_retry = (pend.size() == PEND_DEPTH) || m_haz || (m_valid && insn_retry);
    if (model_ok) begin
      chk("m_if_insn_retry", {63'd0, if_insn_retry}, {63'd0, m_retry});
      chk("m_insn_valid", {63'd0, insn_valid}, {63'd0, m_valid});
      chk("m_insn", {32'd0, insn}, {32'd0, m_insn});
      chk("m_pc", pc, m_pc);
      chk("m_sign_ext", sign_ext, m_imm);
      chk("m_src1", src1, m_src1);
      chk("m_src2", src2, m_src2);
    end
    if (reset) begin
      model_ok = 1'b1;
      for (int r = 0; r < 32; r++) mrf[r] = '0;
      pend.delete();
      m_valid = 1'b0; m_insn = '0; m_pc = '0; m_imm = '0; m_src1 = '0; m_src2 = '0;
    end else if (model_ok) begin
      m_acc  = if_insn_valid && !m_retry;
      m_wval = dest_long ? dest : 64'($signed(dest[31:0]));
      if (m_pop) begin
        m_rd = pend.pop_front();
        if (m_rd != 0) mrf[m_rd] = m_wval;
      end
      if (m_acc) begin
        m_valid = 1'b1;
        m_insn  = if_insn;
        m_pc    = if_pc;
        m_imm   = imm_of(if_insn);
        m_src1  = (c_rs1 == 0) ? 64'd0 : mrf[c_rs1];
        m_src2  = (c_rs2 == 0) ? 64'd0 : mrf[c_rs2];
        if (has_rd(if_insn)) pend.push_back(c_rd);
      end else if (!insn_retry) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] pc_ctr = 64'h1000;
  logic [63:0] pc_x3;

  function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs), 3'b000, 5'(rd), 7'h13};
  endfunction

  task automatic idle();
    if_insn_valid = 1'b0;
    insn_retry    = 1'b0;
    dest_valid    = 1'b0;
    dest_long     = 1'b1;
  endtask

  task automatic drive(input logic [31:0] ins);
    if_insn_valid = 1'b1;
    if_insn       = ins;
    if_pc         = pc_ctr;
    pc_ctr        = pc_ctr + 64'd4;
  endtask

  task automatic wb(input logic [63:0] d, input logic lng);
    dest_valid = 1'b1;
    dest       = d;
    dest_long  = lng;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    reset = 1'b1; idle(); if_insn = '0; if_pc = '0; dest = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_insn_valid", {63'd0, insn_valid}, 64'd0);
    chk("rst_src1", src1, 64'd0);
    chk("rst_sign_ext", sign_ext, 64'd0);
    chk("rst_if_insn_retry", {63'd0, if_insn_retry}, 64'd0);

    // addi x1,x0,-5 then add x2,x1,x1 (RAW on x1)
    cyc(); drive(32'hFFB00093); #2;
    chk("addi_accept", {63'd0, if_insn_retry}, 64'd0);
    cyc(); drive(32'h00108133); #2;
    chk("addi_valid", {63'd0, insn_valid}, 64'd1);
    chk("addi_imm", sign_ext, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("add_stalled", {63'd0, if_insn_retry}, 64'd1);
    cyc(); if_insn_valid = 1'b1; #2;
    chk("add_still_stalled", {63'd0, if_insn_retry}, 64'd1);
    cyc(); if_insn_valid = 1'b1; wb(64'd7, 1'b1); #2;
    chk("add_released", {63'd0, if_insn_retry}, 64'd0);
    cyc(); #2;
    chk("add_src1", src1, 64'd7);
    chk("add_src2", src2, 64'd7);

    // ALU back-pressure: addi x3,x1,5 held for 3 cycles
    cyc(); pc_x3 = pc_ctr; drive(32'h00508193); #2;
    chk("x3_accept", {63'd0, if_insn_retry}, 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); if_insn_valid = 1'b1; insn_retry = 1'b1;
      if (n == 0) drive(32'h00100213);
      #2;
      chk("hold_retry", {63'd0, if_insn_retry}, 64'd1);
      chk("hold_insn", {32'd0, insn}, 64'h0000_0000_0050_8193);
      chk("hold_pc", pc, pc_x3);
      chk("hold_src1", src1, 64'd7);
    end
    @(negedge clk); if_insn_valid = 1'b1; insn_retry = 1'b0; #2;
    chk("hold_release", {63'd0, if_insn_retry}, 64'd0);
    cyc(); #2;
    chk("x4_insn", {32'd0, insn}, 64'h0000_0000_0010_0213);
    // retire x2, x3, x4
    cyc(); wb(64'd100, 1'b1);
    cyc(); wb(64'd101, 1'b1);
    cyc(); wb(64'd102, 1'b1);

    // fill the scoreboard with x5..x8
    for (int r = 5; r <= 8; r++) begin
      cyc(); drive(addi(r, 0, r)); #2;
      chk("fill_accept", {63'd0, if_insn_retry}, 64'd0);
    end
    cyc(); drive(addi(9, 0, 9)); #2;
    chk("full_stall", {63'd0, if_insn_retry}, 64'd1);
    cyc(); if_insn_valid = 1'b1; wb(64'h0000_0000_8000_0000, 1'b0); #2;
    chk("full_pop_same_cycle", {63'd0, if_insn_retry}, 64'd1);
    cyc(); if_insn_valid = 1'b1; #2;
    chk("full_freed", {63'd0, if_insn_retry}, 64'd0);
    cyc(); wb(64'd66, 1'b1);
    cyc(); drive(32'h00028533); #2;   // add x10,x5,x0
    chk("x10_accept", {63'd0, if_insn_retry}, 64'd0);
    cyc(); #2;
    chk("sext_wb", src1, 64'hFFFF_FFFF_8000_0000);
    cyc(); wb(64'd77, 1'b1);
    cyc(); wb(64'd88, 1'b1);
    cyc(); wb(64'd99, 1'b1);
    cyc(); wb(64'hA5A5_0000_1234_5678, 1'b1);
    cyc(); wb(64'd55, 1'b1);          // FIFO empty: ignored

    // x0 destination: no push, stray write-back ignored
    cyc(); drive(32'h00100013); #2;
    chk("x0_accept", {63'd0, if_insn_retry}, 64'd0);
    cyc(); wb(64'hDEAD, 1'b1);
    cyc(); drive(32'h002085B3); #2;   // add x11,x1,x2
    chk("x0_no_pending", {63'd0, if_insn_retry}, 64'd0);
    cyc(); #2;
    chk("x1_kept", src1, 64'd7);
    chk("x2_kept", src2, 64'd100);

    // immediate formats
    cyc(); drive(32'h80000637); // lui x12,0x80000
    cyc(); drive(32'hFE112E23); #2; // sw x1,-4(x2)
    chk("imm_u", sign_ext, 64'hFFFF_FFFF_8000_0000);
    cyc(); drive(32'hFE000CE3); #2; // beq x0,x0,-8
    chk("imm_s", sign_ext, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); drive(32'h001000EF); #2; // jal x1,+2048
    chk("imm_b", sign_ext, 64'hFFFF_FFFF_FFFF_FFF8);
    cyc(); drive(32'hFFF00073); #2; // system: no immediate
    chk("imm_j", sign_ext, 64'h0000_0000_0000_0800);
    cyc(); #2;
    chk("imm_none", sign_ext, 64'd0);

    // reset with x12, x1 pending
    @(negedge clk); reset = 1'b1; idle();
    @(negedge clk); reset = 1'b0; drive(32'h00C086B3); #2; // add x13,x1,x12
    chk("rst_drops_pending", {63'd0, if_insn_retry}, 64'd0);
    cyc(); #2;
    chk("rst_rf_x1", src1, 64'd0);
    chk("rst_rf_x12", src2, 64'd0);
    chk("post_rst_valid", {63'd0, insn_valid}, 64'd1);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
